// File: rtl/scale_mode_sequencer.sv
// Mode-change sequencer for the image-scaling display path: debounces the mode
// switches, blanks on a frame boundary, restarts the copier, then commits geometry.
module scale_mode_sequencer #(
  parameter int IMG_W           = 160,
  parameter int IMG_H           = 120,
  parameter int SCR_W           = 640,
  parameter int SCR_H           = 480,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic       clk_50MHz,
  input  logic       vga_reset,
  input  logic [3:0] sw,
  input  logic       vsync_in,
  input  logic       copy_done,
  output logic       copier_rst_n,
  output logic [3:0] mode,
  output logic [9:0] img_w_amp,
  output logic [9:0] img_h_amp,
  output logic [9:0] x_offset,
  output logic [9:0] y_offset,
  output logic       display_en,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    BOOT_RST,
    WAIT_DONE,
    COMMIT,
    WAIT_FRAME_ON,
    IDLE,
    WAIT_FRAME_OFF
  } state_t;

  typedef struct packed {
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] x;
    logic [9:0] y;
  } geom_t;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [9:0] RST_W = 10'(IMG_W * 2);
  localparam logic [9:0] RST_H = 10'(IMG_H * 2);
  localparam logic [9:0] RST_X = 10'((SCR_W - IMG_W * 2) / 2);
  localparam logic [9:0] RST_Y = 10'((SCR_H - IMG_H * 2) / 2);

  // Scale factor is 2 or 4, so multiply/divide reduce to shifts.
  function automatic geom_t geom_of(input logic [3:0] m);
    geom_t      g;
    logic [9:0] w_src;
    logic [9:0] h_src;
    w_src = 10'(IMG_W);
    h_src = 10'(IMG_H);
    case (m)
      4'b0000, 4'b1000, 4'b0010: begin
        g.w = m[3] ? (w_src << 2) : (w_src << 1);
        g.h = m[3] ? (h_src << 2) : (h_src << 1);
      end
      4'b0001, 4'b0011, 4'b1001: begin
        g.w = m[3] ? (w_src >> 2) : (w_src >> 1);
        g.h = m[3] ? (h_src >> 2) : (h_src >> 1);
      end
      default: begin
        g.w = w_src;
        g.h = h_src;
      end
    endcase
    g.x = (10'(SCR_W) - g.w) >> 1;
    g.y = (10'(SCR_H) - g.h) >> 1;
    return g;
  endfunction

  logic [3:0]      sw_meta_q, sw_sync_q;
  logic            vs_meta_q, vs_sync_q, vs_prev_q;
  logic [3:0]      cand_q, cand_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]      stable_q, stable_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       mode_q, mode_d;
  geom_t            geom_q, geom_d;
  logic             disp_q, disp_d;
  logic             crst_n_q, crst_n_d;
  logic             terr_q, terr_d;

  logic frame_start;
  logic change_req;

  assign frame_start = vs_prev_q & ~vs_sync_q;
  // pending_q is the committed mode in IDLE and the in-flight mode while busy.
  assign change_req  = (stable_q != pending_q);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (sw_sync_q != cand_q) begin
      cand_d   = sw_sync_q;
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = cand_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    geom_d    = geom_q;
    disp_d    = disp_q;
    crst_n_d  = crst_n_q;
    terr_d    = terr_q;
    case (state_q)
      BOOT_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          crst_n_d = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // copy_done is stale until the copier has been out of reset for 2 cycles.
        if (cnt_q >= CNT_W'(2) && copy_done) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          cnt_d   = '0;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        geom_d  = geom_of(pending_q);
        state_d = WAIT_FRAME_ON;
      end
      WAIT_FRAME_ON: begin
        if (frame_start) begin
          disp_d  = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (change_req) begin
          pending_d = stable_q;
          state_d   = WAIT_FRAME_OFF;
        end
      end
      WAIT_FRAME_OFF: begin
        if (frame_start) begin
          disp_d   = 1'b0;
          crst_n_d = 1'b0;
          mode_d   = pending_q;
          cnt_d    = '0;
          state_d  = BOOT_RST;
        end
      end
      default: state_d = BOOT_RST;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      cand_q    <= '0;
      db_cnt_q  <= '0;
      stable_q  <= '0;
      state_q   <= BOOT_RST;
      cnt_q     <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      geom_q    <= '{RST_W, RST_H, RST_X, RST_Y};
      disp_q    <= 1'b0;
      crst_n_q  <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      vs_meta_q <= vsync_in;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      cand_q    <= cand_d;
      db_cnt_q  <= db_cnt_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      geom_q    <= geom_d;
      disp_q    <= disp_d;
      crst_n_q  <= crst_n_d;
      terr_q    <= terr_d;
    end
  end

  assign copier_rst_n = crst_n_q;
  assign mode         = mode_q;
  assign img_w_amp    = geom_q.w;
  assign img_h_amp    = geom_q.h;
  assign x_offset     = geom_q.x;
  assign y_offset     = geom_q.y;
  assign display_en   = disp_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_scale_mode_sequencer.sv
// Bench for scale_mode_sequencer: free-running vsync and copier models, randomized
// modes and copy latencies, expected geometry from a behavioural model.
module tb_scale_mode_sequencer;

  localparam int DB        = 50;
  localparam int RSTC      = 4;
  localparam int TO        = 300;
  localparam int VS_PERIOD = 400;
  localparam int VS_LOW    = 20;
  localparam int WAIT_MAX  = 3000;

  logic       clk_50MHz = 1'b0;
  logic       vga_reset = 1'b0;
  logic [3:0] sw        = 4'b0000;
  logic       vsync_in  = 1'b1;
  logic       copy_done = 1'b0;
  logic       copier_rst_n;
  logic [3:0] mode;
  logic [9:0] img_w_amp, img_h_amp, x_offset, y_offset;
  logic       display_en, busy, timeout_err;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_fall = -100;
  int copy_lat  = 20;
  bit copier_hang = 1'b0;
  int seq_count = 0;
  logic [3:0] cur_mode = 4'b0000;

  scale_mode_sequencer #(
    .IMG_W(160), .IMG_H(120), .SCR_W(640), .SCR_H(480),
    .DEBOUNCE_CYCLES(DB), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .vga_reset   (vga_reset),
    .sw          (sw),
    .vsync_in    (vsync_in),
    .copy_done   (copy_done),
    .copier_rst_n(copier_rst_n),
    .mode        (mode),
    .img_w_amp   (img_w_amp),
    .img_h_amp   (img_h_amp),
    .x_offset    (x_offset),
    .y_offset    (y_offset),
    .display_en  (display_en),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Expected geometry straight from the mode table, in integer arithmetic.
  function automatic logic [39:0] model_geom(input logic [3:0] m);
    int f, w, h;
    f = m[3] ? 4 : 2;
    if (m == 4'b0000 || m == 4'b1000 || m == 4'b0010) begin
      w = 160 * f; h = 120 * f;
    end else if (m == 4'b0001 || m == 4'b0011 || m == 4'b1001) begin
      w = 160 / f; h = 120 / f;
    end else begin
      w = 160; h = 120;
    end
    return {10'(w), 10'(h), 10'((640 - w) / 2), 10'((480 - h) / 2)};
  endfunction

  task automatic tick();
    @(negedge clk_50MHz);
    #1;
  endtask

  // Cycle counter and vsync source: low for VS_LOW of every VS_PERIOD cycles.
  initial begin
    int phase;
    phase = $urandom_range(VS_PERIOD - 1);
    forever begin
      @(negedge clk_50MHz);
      cyc++;
      phase = (phase + 1) % VS_PERIOD;
      if (phase == 0) begin
        vsync_in  = 1'b0;
        last_fall = cyc;
      end else if (phase == VS_LOW) begin
        vsync_in = 1'b1;
      end
    end
  end

  // Copier: done drops while in reset, rises copy_lat cycles after release.
  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk_50MHz);
      if (!copier_rst_n) begin
        copy_done = 1'b0;
        n = 0;
      end else if (!copier_hang) begin
        if (n >= copy_lat) copy_done = 1'b1;
        else n++;
      end
    end
  end

  // Invariants: geometry only moves while blanked and busy; display turns on
  // only with geometry matching the committed mode.
  initial begin
    logic [39:0] prev_geom;
    logic        prev_disp, prev_crst;
    prev_geom = '0; prev_disp = 1'b0; prev_crst = 1'b0;
    forever begin
      tick();
      if (vga_reset) begin
        if ({img_w_amp, img_h_amp, x_offset, y_offset} !== prev_geom) begin
          checks++;
          if (display_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL geom_change_visible display_en=%b busy=%b required 0/1", display_en, busy);
          end
        end
        if (display_en === 1'b1 && prev_disp === 1'b0) begin
          checks++;
          if ({img_w_amp, img_h_amp, x_offset, y_offset} !== model_geom(mode)) begin
            errors++;
            $display("FAIL disp_rise_geom mode=%b got %0d/%0d/%0d/%0d", mode,
                     img_w_amp, img_h_amp, x_offset, y_offset);
          end
        end
        if (copier_rst_n === 1'b0 && prev_crst === 1'b1) seq_count++;
      end
      prev_geom = {img_w_amp, img_h_amp, x_offset, y_offset};
      prev_disp = display_en;
      prev_crst = copier_rst_n;
    end
  end

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check_rst_pulse(input logic [3:0] m, input string tag);
    int  low;
    bit  mode_ok;
    low = 0; mode_ok = 1'b1;
    while (copier_rst_n === 1'b0 && low < 50) begin
      low++;
      if (mode !== m) mode_ok = 1'b0;
      tick();
    end
    checks++;
    if (low != RSTC) begin
      errors++;
      $display("FAIL %s_rst_pulse low for %0d cycles, required %0d", tag, low, RSTC);
    end
    checks++;
    if (!mode_ok || mode !== m) begin
      errors++;
      $display("FAIL %s_rst_mode mode=%b required %b during copier reset", tag, mode, m);
    end
  endtask

  task automatic start_sequence(input logic [3:0] m, input string tag);
    int n;
    n = 0;
    while (display_en !== 1'b0 && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (display_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_blank display_en=%b required 0 within %0d cycles", tag, display_en, WAIT_MAX);
      return;
    end
    checks++;
    if (cyc - last_fall < 2 || cyc - last_fall > 4) begin
      errors++;
      $display("FAIL %s_blank_align blanked %0d cycles after vsync fall, required 2..4", tag, cyc - last_fall);
    end
    check_rst_pulse(m, tag);
  endtask

  task automatic finish_sequence(input logic [3:0] m, input bit terr, input string tag);
    int n;
    n = 0;
    while (display_en !== 1'b1 && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (display_en !== 1'b1) begin
      errors++;
      $display("FAIL %s_enable display_en=%b required 1 within %0d cycles", tag, display_en, WAIT_MAX);
      return;
    end
    checks++;
    if (cyc - last_fall < 2 || cyc - last_fall > 4) begin
      errors++;
      $display("FAIL %s_enable_align enabled %0d cycles after vsync fall, required 2..4", tag, cyc - last_fall);
    end
    checks++;
    if ({img_w_amp, img_h_amp, x_offset, y_offset} !== model_geom(m)) begin
      errors++;
      $display("FAIL %s_geom got %0d/%0d/%0d/%0d required %h", tag,
               img_w_amp, img_h_amp, x_offset, y_offset, model_geom(m));
    end
    checks++;
    if (mode !== m || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_mode mode=%b busy=%b required %b/0", tag, mode, busy, m);
    end
    checks++;
    if (timeout_err !== terr) begin
      errors++;
      $display("FAIL %s_timeout_err got %b required %b", tag, timeout_err, terr);
    end
    cur_mode = m;
  endtask

  task automatic run_mode(input logic [3:0] m, input bit terr, input string tag);
    copy_lat = $urandom_range(5, 80);
    sw = m;
    start_sequence(m, tag);
    finish_sequence(m, terr, tag);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({mode, img_w_amp, img_h_amp, x_offset, y_offset} !== {4'b0000, 10'd320, 10'd240, 10'd160, 10'd120}) begin
      errors++;
      $display("FAIL %s_geom mode=%b geom=%0d/%0d/%0d/%0d required 0000 320/240/160/120",
               tag, mode, img_w_amp, img_h_amp, x_offset, y_offset);
    end
    checks++;
    if ({display_en, copier_rst_n, busy, timeout_err} !== 4'b0010) begin
      errors++;
      $display("FAIL %s_ctrl en/crst/busy/terr=%b%b%b%b required 0010",
               tag, display_en, copier_rst_n, busy, timeout_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_reset_values("reset");
    @(negedge clk_50MHz);
    vga_reset = 1'b1;
    #1;
    check_rst_pulse(4'b0000, "boot");
    finish_sequence(4'b0000, 1'b0, "boot");
    checks++;
    if ({img_w_amp, img_h_amp, x_offset, y_offset} !== {10'd320, 10'd240, 10'd160, 10'd120}) begin
      errors++;
      $display("FAIL boot_geom_const got %0d/%0d/%0d/%0d required 320/240/160/120",
               img_w_amp, img_h_amp, x_offset, y_offset);
    end
  endtask

  task automatic test_scale_up();
    run_mode(4'b1000, 1'b0, "scale_up");
    checks++;
    if ({img_w_amp, img_h_amp, x_offset, y_offset} !== {10'd640, 10'd480, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL scale_up_const got %0d/%0d/%0d/%0d required 640/480/0/0",
               img_w_amp, img_h_amp, x_offset, y_offset);
    end
  endtask

  task automatic test_scale_down();
    run_mode(4'b1001, 1'b0, "scale_down");
    checks++;
    if ({img_w_amp, img_h_amp, x_offset, y_offset} !== {10'd40, 10'd30, 10'd300, 10'd225}) begin
      errors++;
      $display("FAIL scale_down_const got %0d/%0d/%0d/%0d required 40/30/300/225",
               img_w_amp, img_h_amp, x_offset, y_offset);
    end
    run_mode(4'b0101, 1'b0, "native");
    checks++;
    if ({img_w_amp, img_h_amp, x_offset, y_offset} !== {10'd160, 10'd120, 10'd240, 10'd180}) begin
      errors++;
      $display("FAIL native_const got %0d/%0d/%0d/%0d required 160/120/240/180",
               img_w_amp, img_h_amp, x_offset, y_offset);
    end
  endtask

  task automatic test_random_modes();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      do m = 4'($urandom); while (m == cur_mode || m == 4'b0001);
      run_mode(m, 1'b0, "random");
    end
  endtask

  task automatic test_bounce();
    int         start;
    logic [3:0] v;
    start = seq_count;
    v = sw;
    for (int i = 0; i < 20; i++) begin
      do v = 4'($urandom); while (v == sw);
      sw = v;
      repeat (10) tick();
    end
    run_mode(4'b0001, 1'b0, "bounce");
    repeat (2 * VS_PERIOD) tick();
    checks++;
    if (seq_count - start != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_once sequences=%0d busy=%b required 1/0", seq_count - start, busy);
    end
    checks++;
    if ({img_w_amp, img_h_amp, x_offset, y_offset} !== {10'd80, 10'd60, 10'd280, 10'd210}) begin
      errors++;
      $display("FAIL bounce_const got %0d/%0d/%0d/%0d required 80/60/280/210",
               img_w_amp, img_h_amp, x_offset, y_offset);
    end
  endtask

  task automatic test_timeout();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre timeout_err=%b required 0", timeout_err);
    end
    copier_hang = 1'b1;
    sw = 4'b1000;
    start_sequence(4'b1000, "timeout");
    finish_sequence(4'b1000, 1'b1, "timeout");
    copier_hang = 1'b0;
  endtask

  task automatic test_change_during_copy();
    int start;
    start = seq_count;
    copy_lat = 150;
    sw = 4'b0010;
    start_sequence(4'b0010, "midcopy_a");
    repeat (5) tick();
    sw = 4'b0011;
    finish_sequence(4'b0010, 1'b1, "midcopy_a");
    copy_lat = $urandom_range(5, 80);
    start_sequence(4'b0011, "midcopy_b");
    finish_sequence(4'b0011, 1'b1, "midcopy_b");
    checks++;
    if (seq_count - start != 2) begin
      errors++;
      $display("FAIL midcopy_count sequences=%0d required 2", seq_count - start);
    end
  endtask

  task automatic test_reset_mid_copy();
    copier_hang = 1'b1;
    sw = 4'b1001;
    start_sequence(4'b1001, "rst_mid");
    repeat (20) tick();
    @(negedge clk_50MHz);
    vga_reset = 1'b0;
    #1;
    check_reset_values("rst_mid");
    sw = 4'b0000;
    copier_hang = 1'b0;
    repeat (5) tick();
    @(negedge clk_50MHz);
    vga_reset = 1'b1;
    #1;
    check_rst_pulse(4'b0000, "reboot");
    finish_sequence(4'b0000, 1'b0, "reboot");
  endtask

  initial begin
    test_reset();
    test_scale_up();
    test_scale_down();
    test_random_modes();
    test_bounce();
    test_timeout();
    test_change_during_copy();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
